// File: rtl/common_pkg.sv
// Shared types for the fetch path: FSM states, register ids
// and the two-word instruction marker bit.
package common_pkg;

  localparam int FETCH_EXT_BIT = 15;

  typedef enum logic [2:0] {
    IDLE,
    REQ1,
    WB_PC1,
    REQ2,
    WB_PC2,
    DONE
  } fetch_state_e;

  typedef enum logic [2:0] {
    R_ZR  = 3'd0,
    R_PC  = 3'd1,
    R_SP  = 3'd2,
    R_FL  = 3'd3,
    R_IR1 = 3'd4,
    R_IR2 = 3'd5,
    R_A   = 3'd6,
    R_B   = 3'd7
  } reg_id_e;

endpackage

// File: rtl/ir_fetch_unit.sv
// Instruction fetch sequencer: reads one or two words at PC,
// writes IR1/IR2 and the advanced PC through the regfile write port.
module ir_fetch_unit
  import common_pkg::*;
#(
  parameter int P_EXT_BIT = FETCH_EXT_BIT,
  parameter int P_WIDTH   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [P_WIDTH-1:0] i_pc,
  output logic               o_mem_req,
  output logic [P_WIDTH-1:0] o_mem_addr,
  input  logic               i_mem_ack,
  input  logic [P_WIDTH-1:0] i_mem_rdata,
  output logic               o_wr_en,
  output reg_id_e            o_dest_addr,
  output logic [P_WIDTH-1:0] o_dest_data,
  output logic               o_busy,
  output logic               o_done
);

  fetch_state_e       state_q, state_d;
  logic [P_WIDTH-1:0] pc_q, pc_d;
  logic               ext_q, ext_d;
  logic [P_WIDTH-1:0] pc_inc1, pc_inc2;

  logic               req_d;
  logic [P_WIDTH-1:0] addr_d;
  logic               wr_d;
  reg_id_e            dest_d;
  logic [P_WIDTH-1:0] data_d;
  logic               busy_d;
  logic               done_d;

  assign pc_inc1 = pc_q + P_WIDTH'(1);
  assign pc_inc2 = pc_q + P_WIDTH'(2);

  // Outputs are loaded on the same edge as the state they act for,
  // so each write is visible the cycle after its decision.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ext_d   = ext_q;
    req_d   = 1'b0;
    addr_d  = o_mem_addr;
    wr_d    = 1'b0;
    dest_d  = o_dest_addr;
    data_d  = o_dest_data;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start && !o_done) begin
          pc_d    = i_pc;
          req_d   = 1'b1;
          addr_d  = i_pc;
          state_d = REQ1;
        end
      end
      REQ1: begin
        if (i_mem_ack) begin
          wr_d    = 1'b1;
          dest_d  = R_IR1;
          data_d  = i_mem_rdata;
          ext_d   = i_mem_rdata[P_EXT_BIT];
          state_d = WB_PC1;
        end else begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end
      end
      WB_PC1: begin
        wr_d   = 1'b1;
        dest_d = R_PC;
        data_d = pc_inc1;
        if (ext_q) begin
          req_d   = 1'b1;
          addr_d  = pc_inc1;
          state_d = REQ2;
        end else begin
          state_d = DONE;
        end
      end
      REQ2: begin
        if (i_mem_ack) begin
          wr_d    = 1'b1;
          dest_d  = R_IR2;
          data_d  = i_mem_rdata;
          state_d = WB_PC2;
        end else begin
          req_d  = 1'b1;
          addr_d = pc_inc1;
        end
      end
      WB_PC2: begin
        wr_d    = 1'b1;
        dest_d  = R_PC;
        data_d  = pc_inc2;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ext_q       <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_wr_en     <= 1'b0;
      o_dest_addr <= R_ZR;
      o_dest_data <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ext_q       <= ext_d;
      o_mem_req   <= req_d;
      o_mem_addr  <= addr_d;
      o_wr_en     <= wr_d;
      o_dest_addr <= dest_d;
      o_dest_data <= data_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
    end
  end

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Directed bench for ir_fetch_unit: one/two-word fetches,
// wait states, PC wrap, ignored starts and async reset.
module tb_ir_fetch_unit;
  import common_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_pc = '0;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [15:0] i_mem_rdata = '0;
  logic        o_wr_en;
  reg_id_e     o_dest_addr;
  logic [15:0] o_dest_data;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int failures = 0;

  int          nwr;
  logic [2:0]  wr_addr [8];
  logic [15:0] wr_data [8];
  logic [15:0] req_addr [2];
  int          unstable;
  int          lat;

  ir_fetch_unit dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_pc        (i_pc),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_wr_en     (o_wr_en),
    .o_dest_addr (o_dest_addr),
    .o_dest_data (o_dest_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Plays memory with wait_n stall cycles per request and logs
  // every regfile write; returns cycles from start to o_done.
  task automatic do_fetch(input logic [15:0] pc, input logic [15:0] w1,
                          input logic [15:0] w2, input int wait_n,
                          output int l);
    int waitc;
    int reqn;
    nwr = 0;
    l = -1;
    reqn = 0;
    waitc = 0;
    unstable = 0;
    req_addr[0] = 16'hxxxx;
    req_addr[1] = 16'hxxxx;
    tick();
    i_pc = pc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_pc = 16'hDEAD;
    for (int c = 1; c <= 40; c++) begin
      i_mem_ack = 1'b0;
      if (o_wr_en && nwr < 8) begin
        wr_addr[nwr] = o_dest_addr;
        wr_data[nwr] = o_dest_data;
        nwr++;
      end
      if (o_mem_req && reqn < 2) begin
        if (waitc == 0) req_addr[reqn] = o_mem_addr;
        else if (o_mem_addr !== req_addr[reqn]) unstable++;
        if (waitc == wait_n) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = (reqn == 0) ? w1 : w2;
          reqn++;
          waitc = 0;
        end else begin
          waitc++;
        end
      end
      if (o_done) begin
        l = c;
        break;
      end
      tick();
    end
    i_mem_ack = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_req", o_mem_req, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wr", o_wr_en, 0);
    chk("rst_dest", o_dest_addr, R_ZR);
    chk("rst_data", o_dest_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    tick();
    i_rst_n = 1'b1;

    // one-word fetch
    do_fetch(16'h0100, 16'h1234, 16'h0000, 0, lat);
    chk("w1_lat", lat, 4);
    chk("w1_nwr", nwr, 2);
    chk("w1_req0", req_addr[0], 16'h0100);
    chk("w1_a0", wr_addr[0], R_IR1);
    chk("w1_d0", wr_data[0], 16'h1234);
    chk("w1_a1", wr_addr[1], R_PC);
    chk("w1_d1", wr_data[1], 16'h0101);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("done_restart_busy", o_busy, 0);
    chk("done_restart_req", o_mem_req, 0);

    // two-word fetch
    do_fetch(16'h0200, 16'h8001, 16'hABCD, 0, lat);
    chk("w2_lat", lat, 6);
    chk("w2_nwr", nwr, 4);
    chk("w2_req1", req_addr[1], 16'h0201);
    chk("w2_a0", wr_addr[0], R_IR1);
    chk("w2_d0", wr_data[0], 16'h8001);
    chk("w2_d1", wr_data[1], 16'h0201);
    chk("w2_a2", wr_addr[2], R_IR2);
    chk("w2_d2", wr_data[2], 16'hABCD);
    chk("w2_a3", wr_addr[3], R_PC);
    chk("w2_d3", wr_data[3], 16'h0202);

    // three wait states on each request
    do_fetch(16'h0300, 16'h8123, 16'h5555, 3, lat);
    chk("ws_lat", lat, 12);
    chk("ws_stable", unstable, 0);
    chk("ws_nwr", nwr, 4);
    chk("ws_req1", req_addr[1], 16'h0301);
    chk("ws_d2", wr_data[2], 16'h5555);
    chk("ws_d3", wr_data[3], 16'h0302);

    // PC wrap
    do_fetch(16'hFFFF, 16'h8000, 16'h00FF, 0, lat);
    chk("wr_lat", lat, 6);
    chk("wr_req0", req_addr[0], 16'hFFFF);
    chk("wr_req1", req_addr[1], 16'h0000);
    chk("wr_d1", wr_data[1], 16'h0000);
    chk("wr_d2", wr_data[2], 16'h00FF);
    chk("wr_d3", wr_data[3], 16'h0001);

    // start while busy, then stray ack in idle
    tick();
    i_pc = 16'h0500;
    i_start = 1'b1;
    tick();
    i_pc = 16'h0900;
    tick();
    i_start = 1'b0;
    chk("bz_req", o_mem_req, 1);
    chk("bz_addr", o_mem_addr, 16'h0500);
    chk("bz_busy", o_busy, 1);
    i_mem_ack = 1'b1;
    i_mem_rdata = 16'h0007;
    tick();
    i_mem_ack = 1'b0;
    chk("bz_ir1", o_dest_data, 16'h0007);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("bz_pc", o_dest_data, 16'h0501);
    chk("bz_done_early", o_done, 0);
    tick();
    chk("bz_done", o_done, 1);
    tick();
    chk("bz_done_once", o_done, 0);
    chk("bz_idle_busy", o_busy, 0);
    i_mem_ack = 1'b1;
    i_mem_rdata = 16'hFFFF;
    tick();
    i_mem_ack = 1'b0;
    chk("stray_wr", o_wr_en, 0);
    chk("stray_busy", o_busy, 0);
    chk("stray_req", o_mem_req, 0);

    // async reset in REQ2
    i_pc = 16'h0600;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_mem_ack = 1'b1;
    i_mem_rdata = 16'h8000;
    tick();
    i_mem_ack = 1'b0;
    tick();
    chk("mr_req2", o_mem_req, 1);
    chk("mr_addr2", o_mem_addr, 16'h0601);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mr_req", o_mem_req, 0);
    chk("mr_wr", o_wr_en, 0);
    chk("mr_busy", o_busy, 0);
    chk("mr_dest", o_dest_addr, R_ZR);
    tick();
    i_rst_n = 1'b1;

    do_fetch(16'h0040, 16'h0042, 16'h0000, 0, lat);
    chk("pr_lat", lat, 4);
    chk("pr_nwr", nwr, 2);
    chk("pr_d0", wr_data[0], 16'h0042);
    chk("pr_d1", wr_data[1], 16'h0041);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_fetch_unit.md
Name: ir_fetch_unit

Overview:
- Instruction fetch sequencer; drives the register file's single write port.
- On a start pulse: reads one or two words from memory at the current PC via a req/ack handshake, writes them into R_IR1/R_IR2, and writes the advanced PC back to R_PC.
- Sits between the memory bus interface and register_file's write side; the control unit starts it and waits for o_done.

Parameters:
- P_EXT_BIT, 15: bit of the first fetched word that marks a two-word instruction (1 = fetch IR2).
- P_WIDTH, 16: data/address width; fixed at 16 for this core.

Ports:
- i_clk  input  1  clock; all state changes on posedge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle fetch request from control unit.
- i_pc  input  16  current PC value (register file read of R_PC).
- o_mem_req  output  1  memory read request; held high until ack.
- o_mem_addr  output  16  read address; stable while o_mem_req=1.
- i_mem_ack  input  1  one-cycle acknowledge; i_mem_rdata valid in the same cycle.
- i_mem_rdata  input  16  memory read data.
- o_wr_en  output  1  register file write enable.
- o_dest_addr  output  reg_id_e  register file write address.
- o_dest_data  output  16  register file write data.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when the fetch completes.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; o_mem_req=0, o_mem_addr=0, o_wr_en=0, o_dest_addr=R_ZR, o_dest_data=0, o_busy=0, o_done=0.
  - Internal pc_q and ext_q cleared.
  - Reset mid-operation abandons the fetch immediately; any ack already in flight is not retried.
- States: IDLE, REQ1, WB_PC1, REQ2, WB_PC2, DONE.
- IDLE:
  - i_start=1: latch pc_q=i_pc, go to REQ1.
  - i_mem_ack in IDLE is ignored.
- REQ1:
  - o_mem_req=1, o_mem_addr=pc_q.
  - On i_mem_ack, in the same cycle: o_wr_en=1, o_dest_addr=R_IR1, o_dest_data=i_mem_rdata; latch ext_q=i_mem_rdata[P_EXT_BIT]; go to WB_PC1.
  - Without ack: stay in REQ1 indefinitely; no timeout.
- WB_PC1:
  - o_wr_en=1, o_dest_addr=R_PC, o_dest_data=pc_q+1.
  - If ext_q: REQ2, else DONE.
- REQ2:
  - o_mem_req=1, o_mem_addr=pc_q+1.
  - On ack: write R_IR2 with the full 16-bit i_mem_rdata, then go to WB_PC2. The read-side low-byte mask is not this block's concern.
- WB_PC2: o_wr_en=1, o_dest_addr=R_PC, o_dest_data=pc_q+2; go to DONE.
- DONE: o_done=1 for one cycle; go to IDLE.
- Latency from i_start to o_done, with ack on the first request cycle:
  - One-word fetch: 4 cycles.
  - Two-word fetch: 6 cycles.
  - Each extra wait cycle before an ack adds one cycle.
- Outside the write cycles listed above: o_wr_en=0. o_dest_addr/o_dest_data are don't-care but registered-stable.
- o_mem_req drops in the cycle after the ack (registered). Ack and req never cause a double write.
- Arithmetic: PC additions are modulo 2^16. pc_q=0xFFFF gives IR2 address 0x0000 and R_PC written as 0x0000 (one-word fetch) or 0x0001 (two-word fetch).
- i_start while o_busy=1 is ignored; no queuing.
- i_start in the DONE cycle is ignored. The earliest accepted restart is the cycle after o_done.
- i_pc is sampled only at start; later changes have no effect.

Decomposition:
- common_pkg holds:
  - fetch_state_e (IDLE, REQ1, WB_PC1, REQ2, WB_PC2, DONE).
  - reg_id_e, already containing R_IR1, R_IR2, R_PC, R_ZR.
  - Constant FETCH_EXT_BIT=15, the default for P_EXT_BIT.
- No sub-module; single FSM with registered outputs.

Test Plan:
- One-word fetch: i_pc=0x0100, start; ack next cycle with rdata=0x1234 -> writes R_IR1=0x1234, then R_PC=0x0101; o_done 4 cycles after start; exactly 2 o_wr_en pulses.
- Two-word fetch: i_pc=0x0200; first rdata=0x8001, second rdata=0xABCD -> writes R_IR1=0x8001, R_PC=0x0201, R_IR2=0xABCD (full 16 bits), R_PC=0x0202; second request addr=0x0201.
- Wait states: ack delayed 3 cycles on each request -> o_mem_req and o_mem_addr stable throughout; done latency 6+6=12 cycles for a two-word fetch.
- Wrap: i_pc=0xFFFF, first rdata=0x8000 -> IR2 request addr=0x0000; final R_PC=0x0001.
- Start while busy plus stray ack: i_start pulsed in REQ1 and WB_PC1 -> ignored, single done. i_mem_ack in IDLE -> no write, state stays IDLE.
- Reset mid-fetch: assert i_rst_n=0 while in REQ2 -> o_mem_req=0, o_wr_en=0, o_busy=0 immediately (async, before the next clock edge). After release, a new start fetches normally.
